// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
//
// Purpose:
//   Bundles the functional-unit completion handshake and the common data bus
//   (CDB) broadcast outputs of cdb_arbiter into one interface.
//
// Signals:
//   fu_valid  [N_FU]            FU i holds a completed result awaiting broadcast
//   fu_tag    [N_FU][CDB_BITS]  destination physical tag of FU i
//   fu_ready  [N_FU]            combinational grant back to FU i
//   cdb_tag   [N_WAY][CDB_BITS] registered broadcast tags (0 on an idle lane)
//   cdb_valid [N_WAY]           registered lane-valid flags
//   rr_ptr    [PTR_W]           current round-robin start index (debug)
//   grant_cnt / stall_cnt [32]  performance counters, only with CDB_ARB_PERF_EN
//
// Modports:
//   master - the FU / consumer side (drives requests, observes the bus)
//   slave  - the arbiter side
//
// Configuration macro: CDB_ARB_PERF_EN adds the two performance counters.
// ---------------------------------------------------------------------------
`ifndef N_WAY
`define N_WAY 3
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif

interface cdb_arbiter_if #(
  parameter int N_FU     = 5,
  parameter int N_WAY    = `N_WAY,
  parameter int CDB_BITS = `CDB_BITS
);
  localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

  logic [N_FU-1:0]                 fu_valid;
  logic [N_FU-1:0][CDB_BITS-1:0]   fu_tag;
  logic [N_FU-1:0]                 fu_ready;
  logic [N_WAY-1:0][CDB_BITS-1:0]  cdb_tag;
  logic [N_WAY-1:0]                cdb_valid;
  logic [PTR_W-1:0]                rr_ptr;

`ifdef CDB_ARB_PERF_EN
  logic [31:0]                     grant_cnt;
  logic [31:0]                     stall_cnt;

  modport master (
    output fu_valid, fu_tag,
    input  fu_ready, cdb_tag, cdb_valid, rr_ptr, grant_cnt, stall_cnt
  );

  modport slave (
    input  fu_valid, fu_tag,
    output fu_ready, cdb_tag, cdb_valid, rr_ptr, grant_cnt, stall_cnt
  );
`else
  modport master (
    output fu_valid, fu_tag,
    input  fu_ready, cdb_tag, cdb_valid, rr_ptr
  );

  modport slave (
    input  fu_valid, fu_tag,
    output fu_ready, cdb_tag, cdb_valid, rr_ptr
  );
`endif

endinterface

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Shares N_WAY common data bus lanes among N_FU functional-unit completion
//   requesters. Each cycle up to N_WAY requesters with a nonzero tag are
//   granted in round-robin order starting at rr_ptr; their tags are placed on
//   lanes 0..N_WAY-1 in scan order and broadcast one cycle later. Tag 0 means
//   "no broadcast": such a request is acknowledged at once, uses no lane and
//   leaves the pointer alone.
//
// Ports:
//   clock  - system clock, all state updates on posedge
//   reset  - synchronous, active-high
//   bus    - cdb_arbiter_if.slave: fu_valid/fu_tag in, fu_ready (comb) out,
//            cdb_tag/cdb_valid/rr_ptr (registered) out, plus grant_cnt and
//            stall_cnt when CDB_ARB_PERF_EN is defined
//
// Configuration macro: CDB_ARB_PERF_EN
//   Defined   -> grant_cnt counts granted lanes, stall_cnt counts cycles in
//                which a real (nonzero-tag) request was refused.
//   Undefined -> no counter logic; the interface carries no counter signals.
// ---------------------------------------------------------------------------
`ifndef N_WAY
`define N_WAY 3
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif

module cdb_arbiter #(
  parameter int N_FU     = 5,
  parameter int N_WAY    = `N_WAY,
  parameter int CDB_BITS = `CDB_BITS
) (
  input  logic          clock,
  input  logic          reset,
  cdb_arbiter_if.slave  bus
);

  localparam int PTR_W  = (N_FU > 1)  ? $clog2(N_FU)  : 1;
  localparam int LANE_W = (N_WAY > 1) ? $clog2(N_WAY) : 1;

  logic [PTR_W-1:0]                r_rrPtr;
  logic [N_WAY-1:0][CDB_BITS-1:0]  r_cdbTag;
  logic [N_WAY-1:0]                r_cdbValid;

  logic [N_FU-1:0]                 w_fuReady;
  logic [N_WAY-1:0][CDB_BITS-1:0]  w_laneTag;
  logic [N_WAY-1:0]                w_laneValid;
  int                              w_grantCount;
  logic [PTR_W-1:0]                w_lastIdx;
  logic [PTR_W-1:0]                w_nextPtr;
  logic                            w_anyGrant;
  logic                            w_stall;

  // Round-robin scan starting at r_rrPtr. The index is advanced with an
  // explicit wrap so no FU can be visited twice in one cycle. Tag-0 requests
  // are acknowledged without taking a lane; nonzero tags fill lanes in scan
  // order until all N_WAY lanes are used, after which any further real
  // request is a stall.
  always_comb begin
    logic [PTR_W-1:0]   idx;
    logic [LANE_W-1:0]  laneSel;

    w_fuReady    = '0;
    w_laneTag    = '0;
    w_laneValid  = '0;
    w_grantCount = 0;
    w_lastIdx    = '0;
    w_stall      = 1'b0;
    idx          = r_rrPtr;
    laneSel      = '0;

    for (int k = 0; k < N_FU; k++) begin
      if (bus.fu_valid[idx]) begin
        if (bus.fu_tag[idx] == '0) begin
          w_fuReady[idx] = 1'b1;
        end else if (w_grantCount < N_WAY) begin
          laneSel              = w_grantCount[LANE_W-1:0];
          w_fuReady[idx]       = 1'b1;
          w_laneTag[laneSel]   = bus.fu_tag[idx];
          w_laneValid[laneSel] = 1'b1;
          w_lastIdx            = idx;
          w_grantCount         = w_grantCount + 1;
        end else begin
          w_stall = 1'b1;
        end
      end
      idx = (idx == PTR_W'(N_FU - 1)) ? '0 : idx + 1'b1;
    end

    // Handshakes are dropped while reset is asserted.
    if (reset) begin
      w_fuReady = '0;
    end
  end

  // The next scan starts just after the last FU that actually took a lane.
  always_comb begin
    w_anyGrant = (w_grantCount != 0);
    w_nextPtr  = (w_lastIdx == PTR_W'(N_FU - 1)) ? '0 : w_lastIdx + 1'b1;
  end

  // Every lane is rewritten each cycle so an idle lane always reads tag 0,
  // valid 0 and never carries a stale broadcast.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rrPtr    <= '0;
      r_cdbTag   <= '0;
      r_cdbValid <= '0;
    end else begin
      r_cdbTag   <= w_laneTag;
      r_cdbValid <= w_laneValid;
      if (w_anyGrant) begin
        r_rrPtr <= w_nextPtr;
      end
    end
  end

  assign bus.fu_ready  = w_fuReady;
  assign bus.cdb_tag   = r_cdbTag;
  assign bus.cdb_valid = r_cdbValid;
  assign bus.rr_ptr    = r_rrPtr;

`ifdef CDB_ARB_PERF_EN
  logic [31:0] r_grantCnt;
  logic [31:0] r_stallCnt;

  // Free-running counters that wrap naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_grantCnt <= '0;
      r_stallCnt <= '0;
    end else begin
      r_grantCnt <= r_grantCnt + w_grantCount[31:0];
      if (w_stall) begin
        r_stallCnt <= r_stallCnt + 32'd1;
      end
    end
  end

  assign bus.grant_cnt = r_grantCnt;
  assign bus.stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed scenarios followed by a randomized run against a queue-based
// reference model of the round-robin CDB arbitration.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int N_FU     = 5;
  localparam int N_WAY    = 3;
  localparam int CDB_BITS = 6;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  cdb_arbiter_if #(.N_FU(N_FU), .N_WAY(N_WAY), .CDB_BITS(CDB_BITS)) bus ();

  cdb_arbiter #(.N_FU(N_FU), .N_WAY(N_WAY), .CDB_BITS(CDB_BITS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Requests presented by the bench-side FUs
  logic [N_FU-1:0]     reqValid;
  logic [CDB_BITS-1:0] reqTag [N_FU];

  // Reference model state (what the registered outputs should hold)
  int                  mPtr;
  logic [CDB_BITS-1:0] mLaneTag [N_WAY];
  logic [N_WAY-1:0]    mLaneValid;
  logic [31:0]         mGrantCnt;
  logic [31:0]         mStallCnt;

  // Reference model combinational results for the current cycle
  logic [N_FU-1:0]     expReady;
  logic [CDB_BITS-1:0] expLaneTag [N_WAY];
  logic [N_WAY-1:0]    expLaneValid;
  int                  expNextPtr;
  int                  expGrants;
  bit                  expStall;

  task automatic driveBus();
    bus.fu_valid = reqValid;
    for (int i = 0; i < N_FU; i++) bus.fu_tag[i] = reqTag[i];
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Build the scan order as a list of FU indices, then pick the first N_WAY
  // real requesters; tag-0 requesters are simply acknowledged.
  task automatic computeModel();
    int order[$];
    int granted[$];
    expReady     = '0;
    expLaneValid = '0;
    expStall     = 1'b0;
    for (int l = 0; l < N_WAY; l++) expLaneTag[l] = '0;
    for (int k = 0; k < N_FU; k++) order.push_back((mPtr + k) % N_FU);
    foreach (order[j]) begin
      if (reqValid[order[j]]) begin
        if (reqTag[order[j]] == 0) expReady[order[j]] = 1'b1;
        else if (granted.size() < N_WAY) begin
          granted.push_back(order[j]);
          expReady[order[j]] = 1'b1;
        end else expStall = 1'b1;
      end
    end
    foreach (granted[l]) begin
      expLaneTag[l]   = reqTag[granted[l]];
      expLaneValid[l] = 1'b1;
    end
    expGrants  = granted.size();
    expNextPtr = (granted.size() > 0) ? (granted[granted.size()-1] + 1) % N_FU : mPtr;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    reqValid = '1;
    for (int i = 0; i < N_FU; i++) reqTag[i] = CDB_BITS'(33 + i);
    driveBus();
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (bus.fu_ready !== 5'b00000) begin
        errors++;
        $display("[TB] FAIL reset_ready: got %b expected 00000", bus.fu_ready);
      end
      tick();
    end
    checks++;
    if (bus.cdb_tag !== 18'h0) begin
      errors++;
      $display("[TB] FAIL reset_tag: got %h expected 0", bus.cdb_tag);
    end
    checks++;
    if (bus.cdb_valid !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_valid: got %b expected 000", bus.cdb_valid);
    end
    checks++;
    if (bus.rr_ptr !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_ptr: got %0d expected 0", bus.rr_ptr);
    end
`ifdef CDB_ARB_PERF_EN
    checks++;
    if (bus.grant_cnt !== 32'd0 || bus.stall_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", bus.grant_cnt, bus.stall_cnt);
    end
`endif
  endtask

  task automatic test_basic();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.fu_ready !== 5'b00111) begin
      errors++;
      $display("[TB] FAIL basic_ready0: got %b expected 00111", bus.fu_ready);
    end
    tick();
    checks++;
    if (bus.rr_ptr !== 3'd3) begin
      errors++;
      $display("[TB] FAIL basic_ptr0: got %0d expected 3", bus.rr_ptr);
    end
    reqValid = 5'b11000;
    driveBus();
    checks++;
    if (bus.cdb_tag !== {6'd35, 6'd34, 6'd33} || bus.cdb_valid !== 3'b111) begin
      errors++;
      $display("[TB] FAIL basic_cdb1: got %h/%b expected %h/111", bus.cdb_tag, bus.cdb_valid, {6'd35, 6'd34, 6'd33});
    end
    @(negedge clock);
    checks++;
    if (bus.fu_ready !== 5'b11000) begin
      errors++;
      $display("[TB] FAIL basic_ready1: got %b expected 11000", bus.fu_ready);
    end
    tick();
    checks++;
    if (bus.cdb_tag !== {6'd0, 6'd37, 6'd36} || bus.cdb_valid !== 3'b011) begin
      errors++;
      $display("[TB] FAIL basic_cdb2: got %h/%b expected %h/011", bus.cdb_tag, bus.cdb_valid, {6'd0, 6'd37, 6'd36});
    end
    checks++;
    if (bus.rr_ptr !== 3'd0) begin
      errors++;
      $display("[TB] FAIL basic_ptr2: got %0d expected 0", bus.rr_ptr);
    end
    reqValid = '0;
    driveBus();
  endtask

  task automatic test_wrap();
    reqValid = 5'b00111;
    reqTag[0] = 6'd1;
    reqTag[1] = 6'd2;
    reqTag[2] = 6'd3;
    driveBus();
    tick();
    checks++;
    if (bus.rr_ptr !== 3'd3) begin
      errors++;
      $display("[TB] FAIL wrap_setup_ptr: got %0d expected 3", bus.rr_ptr);
    end
    reqValid = 5'b11011;
    reqTag[0] = 6'd40;
    reqTag[1] = 6'd41;
    reqTag[2] = 6'd9;
    reqTag[3] = 6'd43;
    reqTag[4] = 6'd44;
    driveBus();
    @(negedge clock);
    checks++;
    if (bus.fu_ready !== 5'b11001) begin
      errors++;
      $display("[TB] FAIL wrap_ready: got %b expected 11001", bus.fu_ready);
    end
    tick();
    checks++;
    if (bus.cdb_tag !== {6'd40, 6'd44, 6'd43} || bus.cdb_valid !== 3'b111) begin
      errors++;
      $display("[TB] FAIL wrap_cdb: got %h/%b expected %h/111", bus.cdb_tag, bus.cdb_valid, {6'd40, 6'd44, 6'd43});
    end
    checks++;
    if (bus.rr_ptr !== 3'd1) begin
      errors++;
      $display("[TB] FAIL wrap_ptr: got %0d expected 1", bus.rr_ptr);
    end
    reqValid = '0;
    driveBus();
  endtask

  task automatic test_tag_zero();
    reqValid  = 5'b00100;
    reqTag[2] = 6'd0;
    driveBus();
    @(negedge clock);
    checks++;
    if (bus.fu_ready !== 5'b00100) begin
      errors++;
      $display("[TB] FAIL tag0_ready: got %b expected 00100", bus.fu_ready);
    end
    tick();
    checks++;
    if (bus.cdb_valid !== 3'b000 || bus.cdb_tag !== 18'h0) begin
      errors++;
      $display("[TB] FAIL tag0_cdb: got %h/%b expected 0/000", bus.cdb_tag, bus.cdb_valid);
    end
    checks++;
    if (bus.rr_ptr !== 3'd1) begin
      errors++;
      $display("[TB] FAIL tag0_ptr: got %0d expected 1", bus.rr_ptr);
    end
    reqValid = '0;
    driveBus();
  endtask

  task automatic test_fairness();
    int grantCount [N_FU];
    for (int i = 0; i < N_FU; i++) begin
      grantCount[i] = 0;
      reqTag[i]     = CDB_BITS'(10 + i);
    end
    reqValid = '1;
    driveBus();
    repeat (10) begin
      @(negedge clock);
      for (int i = 0; i < N_FU; i++) if (bus.fu_ready[i] === 1'b1) grantCount[i]++;
      checks++;
      if ($countones(bus.fu_ready) != N_WAY) begin
        errors++;
        $display("[TB] FAIL fair_width: got %b expected %0d grants", bus.fu_ready, N_WAY);
      end
      tick();
    end
    for (int i = 0; i < N_FU; i++) begin
      checks++;
      if (grantCount[i] != 6) begin
        errors++;
        $display("[TB] FAIL fair_count_fu%0d: got %0d expected 6", i, grantCount[i]);
      end
    end
    reqValid = '0;
    driveBus();
  endtask

  task automatic test_mid_reset();
    reqValid = '1;
    for (int i = 0; i < N_FU; i++) reqTag[i] = CDB_BITS'(50 + i);
    driveBus();
    tick();
    checks++;
    if (bus.cdb_valid !== 3'b111) begin
      errors++;
      $display("[TB] FAIL midreset_pre: got %b expected 111", bus.cdb_valid);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.fu_ready !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL midreset_ready: got %b expected 00000", bus.fu_ready);
    end
    tick();
    checks++;
    if (bus.cdb_tag !== 18'h0 || bus.cdb_valid !== 3'b000 || bus.rr_ptr !== 3'd0) begin
      errors++;
      $display("[TB] FAIL midreset_out: got %h/%b/%0d expected 0/000/0", bus.cdb_tag, bus.cdb_valid, bus.rr_ptr);
    end
`ifdef CDB_ARB_PERF_EN
    checks++;
    if (bus.grant_cnt !== 32'd0 || bus.stall_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL midreset_counters: got %0d/%0d expected 0/0", bus.grant_cnt, bus.stall_cnt);
    end
`endif
    reset    = 1'b0;
    reqValid = '0;
    driveBus();
  endtask

  task automatic test_random();
    mPtr       = 0;
    mLaneValid = '0;
    mGrantCnt  = '0;
    mStallCnt  = '0;
    for (int l = 0; l < N_WAY; l++) mLaneTag[l] = '0;
    repeat (300) begin
      // Idle FUs may raise a new request; pending ones hold their tag.
      for (int i = 0; i < N_FU; i++) begin
        if (!reqValid[i] && $urandom_range(0, 9) < 6) begin
          reqValid[i] = 1'b1;
          reqTag[i]   = ($urandom_range(0, 7) == 0) ? '0 : CDB_BITS'($urandom_range(1, 63));
        end
      end
      driveBus();
      computeModel();
      @(negedge clock);
      checks++;
      if (bus.fu_ready !== expReady) begin
        errors++;
        $display("[TB] FAIL rand_ready: got %b expected %b", bus.fu_ready, expReady);
      end
      tick();
      mPtr       = expNextPtr;
      mLaneValid = expLaneValid;
      for (int l = 0; l < N_WAY; l++) mLaneTag[l] = expLaneTag[l];
      mGrantCnt  = mGrantCnt + 32'(expGrants);
      if (expStall) mStallCnt = mStallCnt + 32'd1;
      for (int l = 0; l < N_WAY; l++) begin
        checks++;
        if (bus.cdb_tag[l] !== mLaneTag[l]) begin
          errors++;
          $display("[TB] FAIL rand_tag_lane%0d: got %0d expected %0d", l, bus.cdb_tag[l], mLaneTag[l]);
        end
      end
      checks++;
      if (bus.cdb_valid !== mLaneValid) begin
        errors++;
        $display("[TB] FAIL rand_valid: got %b expected %b", bus.cdb_valid, mLaneValid);
      end
      checks++;
      if (bus.rr_ptr !== 3'(mPtr)) begin
        errors++;
        $display("[TB] FAIL rand_ptr: got %0d expected %0d", bus.rr_ptr, mPtr);
      end
`ifdef CDB_ARB_PERF_EN
      checks++;
      if (bus.grant_cnt !== mGrantCnt || bus.stall_cnt !== mStallCnt) begin
        errors++;
        $display("[TB] FAIL rand_counters: got %0d/%0d expected %0d/%0d", bus.grant_cnt, bus.stall_cnt, mGrantCnt, mStallCnt);
      end
`endif
      reqValid = reqValid & ~expReady;
    end
    reqValid = '0;
    driveBus();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_tag_zero();
    test_fairness();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the `N_WAY common data bus (CDB) lanes among N_FU functional-unit completion requesters.
- Each cycle, grants up to `N_WAY pending completions in round-robin order. Drives the granted physical-register tags onto a registered cdb_tag bus.
- cdb_tag feeds the ROB completion input (complete_dest_tag) and the reservation-station wakeup logic.
- Tag value 0 means "no broadcast", the same encoding the ROB completion port uses.

Parameters:
- N_FU, 5, number of requesting functional units.
- N_WAY, `N_WAY (3), number of CDB lanes.
- CDB_BITS, `CDB_BITS (6), physical-register tag width.

Ports:
- clock, input, 1, system clock; all state updates on posedge.
- reset, input, 1, synchronous, active-high.
- fu_valid, input, N_FU, FU i holds a completed result awaiting broadcast.
- fu_tag, input, N_FU x CDB_BITS, destination physical tag of FU i.
- fu_ready, output, N_FU, combinational grant; the transfer occurs on a cycle where fu_valid[i] and fu_ready[i] are both 1.
- cdb_tag, output, N_WAY x CDB_BITS, registered broadcast tags; 0 on an idle lane.
- cdb_valid, output, N_WAY, registered lane-valid flags.
- rr_ptr, output, clog2(N_FU), current round-robin start index (debug).

Behaviour:
- Reset (synchronous, active-high):
  - rr_ptr=0, cdb_tag all 0, cdb_valid all 0.
  - fu_ready is 0 for every FU while reset is high.
- Handshake:
  - Each FU holds fu_valid and fu_tag stable until it sees fu_ready=1 at a posedge.
  - fu_ready never depends on the value of fu_tag, except for the tag-0 rule below.
- Grant selection (combinational):
  - Scan FU indices rr_ptr, rr_ptr+1, ..., wrapping mod N_FU.
  - The first N_WAY FUs with fu_valid=1 and fu_tag!=0 get fu_ready=1, assigned to lanes 0,1,2 in scan order.
  - Remaining requesters get fu_ready=0.
- Tag-0 request (fu_valid=1, fu_tag=0):
  - fu_ready=1 immediately; consumes no lane; never broadcast.
  - Does not affect rr_ptr.
- Latency:
  - The tag granted in cycle t appears on cdb_tag[lane] with cdb_valid[lane]=1 in cycle t+1.
  - Every output lane is rewritten every cycle; unused lanes show tag 0, valid 0. A lane never holds a stale tag.
- Pointer update:
  - If at least one lane is granted, rr_ptr <= (index of last granted FU + 1) mod N_FU.
  - Otherwise rr_ptr holds.
- Fairness:
  - A continuously requesting FU is granted within ceil(N_FU/N_WAY) cycles.
  - N_FU <= N_WAY degenerates to all-grant every cycle.
- Wrap-around: scanning past index N_FU-1 continues at 0; no FU is granted twice in one cycle.
- Duplicate nonzero tags from two FUs in one cycle are illegal upstream. The arbiter does not check for them and broadcasts both.
- Reset mid-operation: pending handshakes are dropped; FUs re-present requests after reset deasserts.

Optional Feature:
- Macro: CDB_ARB_PERF_EN.
- With the macro defined, adds two outputs:
  - grant_cnt (32 bits): increments by the number of lanes granted each cycle.
  - stall_cnt (32 bits): increments by 1 each cycle in which at least one FU with fu_valid=1 and a nonzero tag receives fu_ready=0.
- Both counters are reset to 0 by reset and wrap at 2^32.
- Without the macro, neither the ports nor the counter logic exists; behaviour is otherwise identical.

Test Plan:
- Reset held 3 cycles, all fu_valid=1 -> fu_ready=0, cdb_tag={0,0,0}, cdb_valid=0, rr_ptr=0.
- After reset, fu_valid=5'b11111, tags 33..37 held:
  - Cycle 0: fu_ready=5'b00111, rr_ptr becomes 3.
  - Cycle 1: cdb_tag={33,34,35}, valid 3'b111; fu_ready=5'b11000; FU0-2 deasserted.
  - Cycle 2: cdb_tag={36,37,0}, valid 3'b011.
- rr_ptr=3, fu_valid=5'b11011, tags {40,41,_,43,44} -> grants FU3, FU4, FU0 on lanes 0,1,2; next cdb_tag={43,44,40}; rr_ptr=1.
- FU2 only, fu_valid=5'b00100, tag 0 -> fu_ready[2]=1, next cycle cdb_valid=0, rr_ptr unchanged.
- All five FUs request continuously for 10 cycles -> every FU granted exactly 6 times; no two grants to one FU in the same cycle.
- Assert reset mid-stream while cdb_valid=3'b111 -> next cycle all outputs 0, rr_ptr=0. With CDB_ARB_PERF_EN, both counters read 0.
